// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and widths for the alarm controller.
package alarm_pkg;
    localparam int SECS_W = 8;
    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } alarm_state_t;
endpackage

// File: rtl/sec_timer.sv
// sec_timer: tick prescaler plus seconds down-counter for the timed alarm states.
module sec_timer
    import alarm_pkg::*;
#(
    parameter int TICK_CYCLES = 48_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SECS_W-1:0] load_val,
    output logic              tick,
    output logic              expire,
    output logic              half_phase,
    output logic [SECS_W-1:0] secs_left
);
    localparam int PW = $clog2(TICK_CYCLES);
    logic [PW-1:0] presc;
    assign tick       = presc == PW'(TICK_CYCLES - 1);
    assign expire     = tick & (secs_left == SECS_W'(1));
    assign half_phase = presc < PW'(TICK_CYCLES / 2);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            secs_left <= '0;
        end else if (load) begin
            presc     <= '0;
            secs_left <= load_val;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && secs_left != '0) secs_left <= secs_left - SECS_W'(1);
        end
    end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: sequences exit delay, armed, entry delay and siren from keypad codes and a sensor.
// Define ALARM_DURESS_EN to let the easter-egg code act as a silent duress disarm.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int TICK_CYCLES = 48_000_000,
    parameter int EXIT_SECS   = 10,
    parameter int ENTRY_SECS  = 15,
    parameter int SIREN_SECS  = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_lvl,
    input  logic              disarm_lvl,
    input  logic              egg_lvl,
    input  logic              sensor,
    output logic              armed,
    output logic              siren,
    output logic              beep,
    output logic [2:0]        state_code,
    output logic [SECS_W-1:0] secs_left,
    output logic              silent_alarm
);
    alarm_state_t      state, next;
    logic              prev_arm, prev_disarm, sync1, sync2;
    logic              arm_rise, disarm_rise, duress, load, timed;
    logic              unused_tick, expire, half_phase;
    logic [SECS_W-1:0] load_val, secs;
    // History regs start high so a level held through reset release is not an event.
    assign arm_rise    = arm_lvl & ~prev_arm;
    assign disarm_rise = disarm_lvl & ~prev_disarm;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= DISARMED;
            prev_arm    <= 1'b1;
            prev_disarm <= 1'b1;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
        end else begin
            state       <= next;
            prev_arm    <= arm_lvl;
            prev_disarm <= disarm_lvl;
            sync1       <= sensor;
            sync2       <= sync1;
        end
    end
`ifdef ALARM_DURESS_EN
    logic prev_egg, silent;
    assign duress       = egg_lvl & ~prev_egg & (state != DISARMED);
    assign silent_alarm = silent;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_egg <= 1'b1;
            silent   <= 1'b0;
        end else begin
            prev_egg <= egg_lvl;
            if (duress) silent <= 1'b1;
        end
    end
`else
    logic unused_egg;
    assign unused_egg   = egg_lvl;
    assign duress       = 1'b0;
    assign silent_alarm = 1'b0;
`endif
    always_comb begin
        next = state;
        case (state)
            DISARMED: if (arm_rise) next = EXIT;
            EXIT:     if (expire) next = ARMED;
            ARMED:    if (sync2) next = ENTRY;
            ENTRY:    if (expire) next = ALARM;
            ALARM:    if (expire) next = ARMED;
            default:  next = DISARMED;
        endcase
        if (disarm_rise || duress) next = DISARMED;
    end
    assign load     = (next != state) && (next == EXIT || next == ENTRY || next == ALARM);
    assign load_val = next == EXIT  ? SECS_W'(EXIT_SECS)  :
                      next == ENTRY ? SECS_W'(ENTRY_SECS) : SECS_W'(SIREN_SECS);
    sec_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .tick      (unused_tick),
        .expire    (expire),
        .half_phase(half_phase),
        .secs_left (secs)
    );
    assign timed      = state == EXIT || state == ENTRY || state == ALARM;
    assign armed      = state != DISARMED;
    assign siren      = state == ALARM;
    assign beep       = (state == EXIT || state == ENTRY) && half_phase;
    assign state_code = state;
    assign secs_left  = timed ? secs : '0;
endmodule
